// File: rtl/regfile_mp.sv
// Two-read/two-write register file with per-byte write merge, optional zero
// register, optional write-to-read forwarding and a producer scoreboard.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     rd_addr_1,
    input  logic [ADDR_W-1:0]     rd_addr_2,
    output logic [DATA_W-1:0]     rd_data_1,
    output logic [DATA_W-1:0]     rd_data_2,
    output logic                  rd_busy_1,
    output logic                  rd_busy_2,
    input  logic                  wr_en_a,
    input  logic [ADDR_W-1:0]     wr_addr_a,
    input  logic [DATA_W-1:0]     wr_data_a,
    input  logic [DATA_W/8-1:0]   wr_be_a,
    input  logic                  wr_en_b,
    input  logic [ADDR_W-1:0]     wr_addr_b,
    input  logic [DATA_W-1:0]     wr_data_b,
    input  logic [DATA_W/8-1:0]   wr_be_b,
    input  logic                  rsv_en,
    input  logic [ADDR_W-1:0]     rsv_addr,
    output logic [(1<<ADDR_W)-1:0] busy_vec,
    output logic [ADDR_W:0]       busy_cnt
);
    localparam int NREG = 1 << ADDR_W;
    localparam int NB   = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
    logic              fwd_1, fwd_2;

    // Next-state of every entry: B wins per byte, A fills bytes only it enables.
    always_comb begin
        for (int n = 0; n < NREG; n++) begin
            mem_d[n] = mem_q[n];
            for (int i = 0; i < NB; i++) begin
                if (wr_en_b && wr_addr_b == ADDR_W'(n) && wr_be_b[i]) begin
                    mem_d[n][8*i +: 8] = wr_data_b[8*i +: 8];
                end else if (wr_en_a && wr_addr_a == ADDR_W'(n) && wr_be_a[i]) begin
                    mem_d[n][8*i +: 8] = wr_data_a[8*i +: 8];
                end
            end
        end
        if (ZERO_REG != 0) begin
            mem_d[0] = '0;
        end
    end

    // A reservation issued in the same cycle as a completing write is a newer
    // producer, so the set term is applied after the clear term.
    always_comb begin
        busy_d     = busy_q;
        busy_cnt_d = '0;
        if (wr_en_a) busy_d[wr_addr_a] = 1'b0;
        if (wr_en_b) busy_d[wr_addr_b] = 1'b0;
        if (rsv_en)  busy_d[rsv_addr]  = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
        for (int n = 0; n < NREG; n++) begin
            busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[n]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // mem_d equals mem_q for untouched entries, so forwarding reads mem_d directly.
    always_comb begin
        fwd_1 = (BYPASS != 0) &&
                ((wr_en_a && wr_addr_a == rd_addr_1) || (wr_en_b && wr_addr_b == rd_addr_1));
        fwd_2 = (BYPASS != 0) &&
                ((wr_en_a && wr_addr_a == rd_addr_2) || (wr_en_b && wr_addr_b == rd_addr_2));
        rd_data_1 = (BYPASS != 0) ? mem_d[rd_addr_1] : mem_q[rd_addr_1];
        rd_data_2 = (BYPASS != 0) ? mem_d[rd_addr_2] : mem_q[rd_addr_2];
        rd_busy_1 = busy_q[rd_addr_1] && !fwd_1;
        rd_busy_2 = busy_q[rd_addr_2] && !fwd_2;
    end

    assign busy_vec = busy_q;
    assign busy_cnt = busy_cnt_q;

endmodule
